coreabc_fetch_seq: RTL
======================

Name: coreabc_fetch_seq

Overview:
- Instruction fetch sequencer for the CoreABC controller; sits directly upstream of the instruction NVM block.
- Owns the program counter and a small call/return stack.
- Drives the NVM START/ADDRESS handshake and honours STALL.
- Captures each returned instruction word into an instruction register, which it presents to the execute stage with a valid/accept handshake.

Parameters:
ICWIDTH, 8, program counter / NVM address width
ICDEPTH, 256, number of valid instruction locations (may be non-power-of-2)
IWWIDTH, 58, instruction word width
STACKDEPTH, 4, call-stack entries (1..16)

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
ENABLE  in  1  run request; fetching proceeds while high
RESTART  in  1  synchronous; force PC=0, empty stack
NVM_START  out  1  one-cycle fetch request to NVM
NVM_ADDRESS  out  ICWIDTH  fetch address, held stable from START until capture
NVM_STALL  in  1  NVM busy; instruction not yet valid
NVM_INSTRUCTION  in  IWWIDTH  instruction word from NVM
IR_VALID  out  1  instruction register holds a fetched word
IR  out  IWWIDTH  instruction register
IR_PC  out  ICWIDTH  address the IR word was fetched from
IR_ACCEPT  in  1  execute stage consumes IR this cycle (ignored when IR_VALID=0)
BR_VALID  in  1  branch qualifier, sampled only with IR_ACCEPT=1
BR_TYPE  in  2  00 jump, 01 call, 10 return, 11 reserved (treated as no branch)
BR_TARGET  in  ICWIDTH  jump/call target
ERR  out  2  sticky flags: bit0 stack over/underflow, bit1 target out of range

Behaviour:
- Reset (async, RST=1):
  - State=IDLE; PC=0; stack empty.
  - All outputs 0: NVM_START, NVM_ADDRESS, IR_VALID, IR, IR_PC, ERR.
- FSM states: IDLE, FETCH, WAIT, HOLD.
- IDLE:
  - If ENABLE=1 and RESTART=0, go to FETCH.
  - RESTART in IDLE sets PC=0 and empties the stack; stays IDLE.
- FETCH (exactly one cycle):
  - NVM_START=1, NVM_ADDRESS=PC.
  - Next state WAIT.
- WAIT:
  - NVM_START=0; NVM_ADDRESS holds the fetch address.
  - While NVM_STALL=1, stay in WAIT.
  - On the first edge with NVM_STALL=0: IR<=NVM_INSTRUCTION, IR_PC<=fetch address, IR_VALID<=1, go to HOLD.
  - Minimum latency START-to-IR_VALID is 2 edges (FETCH edge, then WAIT edge with STALL low).
- HOLD:
  - IR, IR_PC and IR_VALID are stable until IR_ACCEPT=1.
  - On accept: IR_VALID<=0 and next PC is computed.
  - Next state: FETCH if ENABLE=1, else IDLE.
  - No prefetch; at most one fetch outstanding.
- Next-PC rules, evaluated on accept:
  - No branch: PC=IR_PC+1; wraps to 0 when IR_PC=ICDEPTH-1.
  - Jump: PC=BR_TARGET.
  - Call: push IR_PC+1 (same wrap rule), PC=BR_TARGET.
  - Return: pop, PC=popped value.
  - BR_TARGET>=ICDEPTH: PC=0, ERR[1]<=1.
  - Call with stack full: push discarded, jump still taken, ERR[0]<=1.
  - Return with stack empty: PC=IR_PC+1, ERR[0]<=1.
- ERR bits clear only on RST; RESTART does not clear them.
- RESTART (priority over branch and accept):
  - In HOLD: IR_VALID<=0, PC=0, stack emptied; next state FETCH if ENABLE else IDLE.
  - In FETCH or WAIT: the NVM transfer is not aborted. The sequencer completes WAIT until NVM_STALL=0, discards the returned word (IR_VALID stays 0), then fetches from PC=0.
  - A pending-restart flag records the request until then.
- ENABLE deasserted mid-fetch: the current fetch and HOLD complete normally; the sequencer idles after accept. PC is retained, so re-enabling resumes at PC.
- IR_ACCEPT and BR_VALID are ignored outside HOLD.
- NVM_START never asserts while in WAIT or HOLD.

Test Plan:
- Reset, ENABLE=1, NVM_STALL tied 0, IR_ACCEPT tied 1 -> NVM_ADDRESS sequence 0,1,2,3; IR_VALID high every 3rd cycle; IR_PC matches; ERR=00.
- NVM_STALL held high 5 cycles after START at PC=7 -> NVM_ADDRESS=7 stable throughout; IR captured on the first STALL-low edge; a single START pulse observed.
- Call to 0x40 from PC=0x10, then return -> fetches 0x40, then 0x11. Five nested calls with STACKDEPTH=4 -> ERR[0]=1; the fifth call still reaches its target; four returns unwind correctly.
- Jump BR_TARGET=250 with ICDEPTH=200 -> next fetch at 0, ERR[1]=1. Sequential fetch at PC=199 -> next address 0, ERR unchanged.
- RESTART pulsed during WAIT at PC=0x22 with STALL high 3 more cycles -> no IR_VALID for the 0x22 word; next START has ADDRESS=0.
- Async RST asserted in HOLD mid-cycle -> IR_VALID, NVM_START and ERR go to 0 immediately; after release with ENABLE=1, first fetch is at address 0.

Source files
------------

// File: rtl/coreabc_fetch_seq.sv
// CoreABC instruction fetch sequencer: owns the PC and call stack, runs the
// NVM START/ADDRESS/STALL handshake and hands words to execute via IR_VALID/IR_ACCEPT.
module coreabc_fetch_seq #(
  parameter int ICWIDTH    = 8,
  parameter int ICDEPTH    = 256,
  parameter int IWWIDTH    = 58,
  parameter int STACKDEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ENABLE,
  input  logic               RESTART,
  output logic               NVM_START,
  output logic [ICWIDTH-1:0] NVM_ADDRESS,
  input  logic               NVM_STALL,
  input  logic [IWWIDTH-1:0] NVM_INSTRUCTION,
  output logic               IR_VALID,
  output logic [IWWIDTH-1:0] IR,
  output logic [ICWIDTH-1:0] IR_PC,
  input  logic               IR_ACCEPT,
  input  logic               BR_VALID,
  input  logic [1:0]         BR_TYPE,
  input  logic [ICWIDTH-1:0] BR_TARGET,
  output logic [1:0]         ERR
);

  localparam int SPW = $clog2(STACKDEPTH + 1);
  localparam logic [SPW-1:0]     SP_FULL = SPW'(STACKDEPTH);
  localparam logic [ICWIDTH-1:0] PC_LAST = ICWIDTH'(ICDEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;
  typedef enum logic [1:0] {BR_JUMP, BR_CALL, BR_RET, BR_RSVD} br_t;

  state_t state, state_nx;
  logic [ICWIDTH-1:0] pc, pc_nx, pc_inc;
  logic [SPW-1:0]     sp, sp_nx;
  logic               push;
  logic [1:0]         err_set;
  logic               rst_pend;
  logic               capture, discard, tgt_oob;

  // Stack is sized to the pointer range so sp indexes it without truncation;
  // entries at or above STACKDEPTH are never written.
  logic [ICWIDTH-1:0] stk [2**SPW];

  // PC is only updated on accept/restart, so it doubles as the held fetch address.
  assign NVM_START   = (state == S_FETCH);
  assign NVM_ADDRESS = pc;

  assign pc_inc  = (pc == PC_LAST) ? '0 : pc + 1'b1;
  assign tgt_oob = (33'(BR_TARGET) >= 33'(ICDEPTH));
  assign capture = (state == S_WAIT) && !NVM_STALL;
  assign discard = rst_pend || RESTART;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    sp_nx    = sp;
    push     = 1'b0;
    err_set  = 2'b00;
    case (state)
      S_IDLE: begin
        if (RESTART) begin
          pc_nx = '0;
          sp_nx = '0;
        end else if (ENABLE) begin
          state_nx = S_FETCH;
        end
      end
      S_FETCH: state_nx = S_WAIT;
      S_WAIT: begin
        if (capture) begin
          if (discard) begin
            pc_nx    = '0;
            sp_nx    = '0;
            state_nx = ENABLE ? S_FETCH : S_IDLE;
          end else begin
            state_nx = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (RESTART) begin
          pc_nx    = '0;
          sp_nx    = '0;
          state_nx = ENABLE ? S_FETCH : S_IDLE;
        end else if (IR_ACCEPT) begin
          state_nx = ENABLE ? S_FETCH : S_IDLE;
          pc_nx    = pc_inc;
          if (BR_VALID) begin
            case (BR_TYPE)
              BR_JUMP: pc_nx = BR_TARGET;
              BR_CALL: begin
                pc_nx = BR_TARGET;
                if (sp == SP_FULL) begin
                  err_set[0] = 1'b1;
                end else begin
                  push  = 1'b1;
                  sp_nx = sp + 1'b1;
                end
              end
              BR_RET: begin
                if (sp == '0) begin
                  err_set[0] = 1'b1;
                end else begin
                  pc_nx = stk[sp - 1'b1];
                  sp_nx = sp - 1'b1;
                end
              end
              default: ;
            endcase
            // Out-of-range jump/call target falls back to address 0.
            if ((BR_TYPE == BR_JUMP || BR_TYPE == BR_CALL) && tgt_oob) begin
              pc_nx      = '0;
              err_set[1] = 1'b1;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      pc       <= '0;
      sp       <= '0;
      rst_pend <= 1'b0;
      IR_VALID <= 1'b0;
      IR       <= '0;
      IR_PC    <= '0;
      ERR      <= 2'b00;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      sp    <= sp_nx;
      ERR   <= ERR | err_set;
      // A restart during an in-flight transfer is remembered until the word returns.
      if (capture)
        rst_pend <= 1'b0;
      else if (RESTART && (state == S_FETCH || state == S_WAIT))
        rst_pend <= 1'b1;
      if (capture && !discard) begin
        IR_VALID <= 1'b1;
        IR       <= NVM_INSTRUCTION;
        IR_PC    <= pc;
      end else if (state == S_HOLD && (RESTART || IR_ACCEPT)) begin
        IR_VALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) stk[sp] <= pc_inc;
  end

endmodule
